// File: rtl/alu_pkg.sv
// Shared types and constants for the operand loader.
//   state_t : load-sequence FSM encoding (WAIT_A, WAIT_B, VALID)
//   COUNT_W : width of the completed-handshake counter
package alu_pkg;

    localparam int COUNT_W = 8;

    typedef enum logic [1:0] {
        WAIT_A = 2'b00,
        WAIT_B = 2'b01,
        VALID  = 2'b10
    } state_t;

endpackage

// File: rtl/rise_detect.sv
// Single-cycle pulse on a 0->1 transition of a level input.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   in    : level input (already synchronised)
//   pulse : high for the one cycle in which in is 1 and was 0 the cycle before
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic r_prev;
    // Set when the input is high across reset release. A level that was
    // already high must fall before it can count as a new event.
    logic r_blocked;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev    <= 1'b0;
            r_blocked <= in;
        end else begin
            r_prev    <= in;
            r_blocked <= r_blocked & in;
        end
    end

    assign pulse = in & ~r_prev & ~r_blocked;

endmodule

// File: rtl/operand_loader.sv
// Captures two N-bit operands from one input bus on successive load events
// and presents them as a valid pair until the downstream stage accepts.
//   clk, rst        : clock and synchronous active-high reset
//   data_in [N]     : operand value to capture
//   load            : level request, acted on at its rising edge
//   clr             : abort the current sequence (returns to WAIT_A)
//   op_ready        : downstream accepts the pair while op_valid is high
//   a_out, b_out [N]: captured operands
//   op_valid        : registered, high exactly while in VALID
//   state_o [2]     : current state encoding
//   op_count [8]    : completed handshakes, modulo 256
//
// state  | meaning
// WAIT_A | waiting for the load event that captures operand A
// WAIT_B | A held, waiting for the load event that captures operand B
// VALID  | pair complete; waiting for op_ready, load events dropped
module operand_loader
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       data_in,
    input  logic               load,
    input  logic               clr,
    input  logic               op_ready,
    output logic [N-1:0]       a_out,
    output logic [N-1:0]       b_out,
    output logic               op_valid,
    output logic [1:0]         state_o,
    output logic [COUNT_W-1:0] op_count
);

    localparam logic [COUNT_W-1:0] COUNT_ONE = 1;

    state_t               r_state;
    logic [N-1:0]         r_a;
    logic [N-1:0]         r_b;
    logic                 r_op_valid;
    logic [COUNT_W-1:0]   r_count;

    state_t               w_next;
    logic                 w_load_evt;
    logic                 w_cap_a;
    logic                 w_cap_b;
    logic                 w_done;

    rise_detect u_rise_detect (
        .clk   (clk),
        .rst   (rst),
        .in    (load),
        .pulse (w_load_evt)
    );

    always_comb begin
        w_next  = r_state;
        w_cap_a = 1'b0;
        w_cap_b = 1'b0;
        w_done  = 1'b0;
        if (clr) begin
            w_next = WAIT_A;
        end else begin
            case (r_state)
                WAIT_A: begin
                    if (w_load_evt) begin
                        w_cap_a = 1'b1;
                        w_next  = WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (w_load_evt) begin
                        w_cap_b = 1'b1;
                        w_next  = VALID;
                    end
                end
                VALID: begin
                    // Load events here are dropped, even alongside op_ready.
                    if (op_ready) begin
                        w_done = 1'b1;
                        w_next = WAIT_A;
                    end
                end
                default: w_next = WAIT_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= WAIT_A;
            r_a        <= '0;
            r_b        <= '0;
            r_op_valid <= 1'b0;
            r_count    <= '0;
        end else begin
            r_state    <= w_next;
            // Registered copy of the next state so op_valid tracks VALID
            // without a combinational path from op_ready.
            r_op_valid <= (w_next == VALID);
            if (w_cap_a) r_a <= data_in;
            if (w_cap_b) r_b <= data_in;
            if (w_done)  r_count <= r_count + COUNT_ONE;
        end
    end

    assign a_out    = r_a;
    assign b_out    = r_b;
    assign op_valid = r_op_valid;
    assign state_o  = r_state;
    assign op_count = r_count;

endmodule

// File: tb/tb_operand_loader.sv
// Directed testbench for operand_loader (N=4). Inputs change 1 ns after
// each rising edge; outputs are checked at the same point.
module tb_operand_loader;

    logic       clk;
    logic       rst;
    logic [3:0] data_in;
    logic       load;
    logic       clr;
    logic       op_ready;
    logic [3:0] a_out;
    logic [3:0] b_out;
    logic       op_valid;
    logic [1:0] state_o;
    logic [7:0] op_count;

    int vectors;
    int miscompares;

    operand_loader #(.N(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .load     (load),
        .clr      (clr),
        .op_ready (op_ready),
        .a_out    (a_out),
        .b_out    (b_out),
        .op_valid (op_valid),
        .state_o  (state_o),
        .op_count (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load(input logic [3:0] d);
        data_in = d;
        load    = 1'b1;
        step();
        load    = 1'b0;
        step();
    endtask

    task automatic handshake(input logic [3:0] a, input logic [3:0] b);
        pulse_load(a);
        pulse_load(b);
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1; data_in = 4'h0; load = 1'b0; clr = 1'b0; op_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_state", state_o, 2'b00);
        chk("rst_a", a_out, 4'h0);
        chk("rst_b", b_out, 4'h0);
        chk("rst_valid", op_valid, 1'b0);
        chk("rst_count", op_count, 8'd0);

        // Capture A then B
        data_in = 4'hA; load = 1'b1;
        step();
        chk("capA_state", state_o, 2'b01);
        chk("capA_a", a_out, 4'hA);
        chk("capA_valid", op_valid, 1'b0);
        load = 1'b0;
        step();
        data_in = 4'h5; load = 1'b1;
        step();
        chk("capB_valid", op_valid, 1'b1);
        chk("capB_a", a_out, 4'hA);
        chk("capB_b", b_out, 4'h5);
        chk("capB_state", state_o, 2'b10);
        load = 1'b0;
        step();

        // Load in VALID is ignored, then handshake
        data_in = 4'hF; load = 1'b1;
        step();
        chk("valid_ld_b", b_out, 4'h5);
        chk("valid_ld_st", state_o, 2'b10);
        load = 1'b0;
        step();
        chk("valid_hold", op_valid, 1'b1);
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
        chk("hs_state", state_o, 2'b00);
        chk("hs_count", op_count, 8'd1);
        chk("hs_valid", op_valid, 1'b0);
        chk("hs_keep_a", a_out, 4'hA);
        chk("hs_keep_b", b_out, 4'h5);
        // Pending load event must not have been queued
        step();
        chk("no_queue", state_o, 2'b00);

        // op_ready outside VALID does nothing
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
        chk("rdy_idle_cnt", op_count, 8'd1);

        // Held load: one capture only
        data_in = 4'h3; load = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 4) data_in = 4'h7;
        end
        load = 1'b0;
        step();
        chk("held_a", a_out, 4'h3);
        chk("held_b", b_out, 4'h5);
        chk("held_state", state_o, 2'b01);

        // clr with load in WAIT_B
        data_in = 4'h9; load = 1'b1; clr = 1'b1;
        step();
        clr = 1'b0; load = 1'b0;
        chk("clr_state", state_o, 2'b00);
        chk("clr_a", a_out, 4'h3);
        chk("clr_b", b_out, 4'h5);
        step();
        chk("clr_stay", state_o, 2'b00);

        // load and op_ready together in VALID: handshake wins
        pulse_load(4'h1);
        pulse_load(4'h2);
        data_in = 4'hE; load = 1'b1; op_ready = 1'b1;
        step();
        load = 1'b0; op_ready = 1'b0;
        chk("ldrdy_state", state_o, 2'b00);
        chk("ldrdy_count", op_count, 8'd2);
        chk("ldrdy_a", a_out, 4'h1);
        step();

        // clr beats op_ready in VALID
        pulse_load(4'h6);
        pulse_load(4'hC);
        clr = 1'b1; op_ready = 1'b1;
        step();
        clr = 1'b0; op_ready = 1'b0;
        chk("clrrdy_state", state_o, 2'b00);
        chk("clrrdy_count", op_count, 8'd2);
        chk("clrrdy_b", b_out, 4'hC);

        // Load held through reset release
        rst = 1'b1; load = 1'b1; data_in = 4'hB;
        step();
        rst = 1'b0;
        step();
        step();
        chk("rstld_state", state_o, 2'b00);
        chk("rstld_a", a_out, 4'h0);
        load = 1'b0;
        step();
        load = 1'b1;
        step();
        load = 1'b0;
        chk("rstld_cap", state_o, 2'b01);
        chk("rstld_capa", a_out, 4'hB);
        clr = 1'b1;
        step();
        clr = 1'b0;

        // Counter wrap
        for (int i = 0; i < 256; i++) begin
            handshake(4'(i), 4'(i + 1));
            if (i == 254) chk("cnt_255", op_count, 8'd255);
        end
        chk("cnt_wrap", op_count, 8'd0);
        chk("wrap_a", a_out, 4'hF);
        chk("wrap_b", b_out, 4'h0);

        // Reset while VALID
        handshake(4'h4, 4'h8);
        pulse_load(4'hD);
        pulse_load(4'h2);
        chk("prerst_valid", op_valid, 1'b1);
        chk("prerst_count", op_count, 8'd1);
        rst = 1'b1; op_ready = 1'b1; load = 1'b1;
        step();
        rst = 1'b0; op_ready = 1'b0; load = 1'b0;
        chk("vrst_valid", op_valid, 1'b0);
        chk("vrst_a", a_out, 4'h0);
        chk("vrst_b", b_out, 4'h0);
        chk("vrst_count", op_count, 8'd0);
        chk("vrst_state", state_o, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 SHALL have parameter N, default 4, operand width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port data_in  input  N  operand value presented by switches or upstream logic.
REQ-005 SHALL have port load  input  1  level request to capture data_in; synchronised and debounced outside this block.
REQ-006 SHALL have port clr  input  1  synchronous abort of the current load sequence.
REQ-007 SHALL have port op_ready  input  1  downstream bitwise stage accepts the operand pair.
REQ-008 SHALL have port a_out  output  N  captured operand A, fed to the N-bit bitwise stage.
REQ-009 SHALL have port b_out  output  N  captured operand B, fed to the N-bit bitwise stage.
REQ-010 SHALL have port op_valid  output  1  operand pair complete and stable.
REQ-011 SHALL have port state_o  output  2  current FSM state encoding, for LEDs.
REQ-012 SHALL have port op_count  output  8  number of completed handshakes, modulo 256.

Function
REQ-013 SHALL act on load only at a 0->1 transition: load high this cycle and low the previous cycle; a held level SHALL produce one event.
REQ-014 SHALL implement FSM states WAIT_A=2'b00, WAIT_B=2'b01, VALID=2'b10; 2'b11 SHALL be unreachable and SHALL return to WAIT_A on the next edge.
REQ-015 WAIT_A + load event: SHALL register a_out<=data_in and go to WAIT_B.
REQ-016 WAIT_B + load event: SHALL register b_out<=data_in and go to VALID.
REQ-017 op_valid SHALL be a registered output, high exactly while state is VALID, i.e. first high in the cycle after the B capture edge.
REQ-018 In VALID, a_out and b_out SHALL stay constant, and load events SHALL be ignored; they SHALL not be queued.
REQ-019 In VALID with op_ready=1 at an edge: SHALL go to WAIT_A and increment op_count; 255 SHALL wrap to 0.
REQ-020 op_ready SHALL be ignored outside VALID; op_valid SHALL not depend combinationally on op_ready.
REQ-021 a_out and b_out SHALL retain their last values after the handshake until overwritten by the next capture.
REQ-022 clr=1 at an edge SHALL force WAIT_A, leave a_out, b_out and op_count unchanged, and take priority over load and op_ready in the same cycle.
REQ-023 load event and op_ready in the same VALID cycle: the handshake SHALL complete and the load SHALL be discarded.

Reset
REQ-024 On rst=1 at an edge, the block SHALL set state to WAIT_A, a_out=0, b_out=0, op_valid=0, op_count=0, and the edge-detector history to 0.
REQ-025 rst SHALL override clr, load and op_ready, including mid-sequence (WAIT_B or VALID).
REQ-026 A load held high through the release of reset SHALL not produce a capture until it falls and rises again.

Structure
REQ-027 The state typedef (enum of WAIT_A, WAIT_B, VALID) SHALL live in the shared package alu_pkg, together with the op_count width constant COUNT_W=8.
REQ-028 The 0->1 detection on load SHALL be a separate sub-module, rise_detect (clk, rst, in, pulse).
REQ-029 Implementation SHALL be parameter-clean for N=1..32.

Verification
REQ-030 The bench SHALL cover: reset; load pulse with data_in=4'hA; load pulse with data_in=4'h5 -> the cycle after the second capture, op_valid=1, a_out=A, b_out=5, state_o=10.
REQ-031 The bench SHALL cover: load held high for 10 cycles in WAIT_A -> only A is captured and state_o=01.
REQ-032 The bench SHALL cover: in VALID, a new load pulse with data_in=4'hF -> b_out stays 5; then op_ready=1 -> state_o=00 and op_count=1.
REQ-033 The bench SHALL cover: in WAIT_B, clr=1 together with a load pulse -> state_o=00, b_out unchanged, a_out unchanged.
REQ-034 The bench SHALL cover: 256 complete handshakes -> op_count wraps to 0.
REQ-035 The bench SHALL cover: rst asserted in VALID -> next cycle op_valid=0, a_out=0, b_out=0, op_count=0.
